// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access stage: one data-memory transaction per instruction
// Aligns store data, extracts and extends load data, stalls the pipeline until done.
module mem_access #(
  parameter int XLEN      = 64,
  parameter int BUS_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 me_mem_rena,
  input  logic                 me_mem_wena,
  input  logic                 me_mem_ext_un,
  input  logic [BUS_BYTES-1:0] me_mem_byte_enable,
  input  logic [XLEN-1:0]      me_alu_result,
  input  logic [XLEN-1:0]      me_new_rs2_data,
  input  logic                 me_exception_flag,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_req_wen,
  output logic [XLEN-1:0]      dmem_req_addr,
  output logic [XLEN-1:0]      dmem_req_wdata,
  output logic [BUS_BYTES-1:0] dmem_req_wstrb,
  input  logic                 dmem_resp_valid,
  input  logic [XLEN-1:0]      dmem_resp_rdata,
  output logic [XLEN-1:0]      me_load_data,
  output logic                 me_misalign,
  output logic                 stall_req
);

  localparam int OFFW  = $clog2(BUS_BYTES);
  localparam int SIZEW = OFFW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        addr_q, addr_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;
  logic [BUS_BYTES-1:0]   wstrb_q, wstrb_d;
  logic                   wen_q, wen_d;
  logic [SIZEW-1:0]       size_q, size_d;
  logic [OFFW-1:0]        off_q, off_d;
  logic                   ext_un_q, ext_un_d;
  logic [XLEN-1:0]        load_data_q, load_data_d;

  logic [SIZEW-1:0]       size;
  logic [OFFW-1:0]        addr_off;
  logic [OFFW-1:0]        size_mask;
  logic                   mem_op;
  logic                   access;
  logic [XLEN-1:0]        shifted;
  logic [XLEN-1:0]        load_ext;

  always_comb begin
    size = '0;
    for (int i = 0; i < BUS_BYTES; i++) begin
      size = size + SIZEW'(me_mem_byte_enable[i]);
    end
  end

  // Natural alignment: offset must be a multiple of the power-of-two access size.
  assign addr_off    = me_alu_result[OFFW-1:0];
  assign size_mask   = OFFW'(size - SIZEW'(1));
  assign mem_op      = (me_mem_rena | me_mem_wena) & ~me_exception_flag;
  assign me_misalign = mem_op & ((addr_off & size_mask) != '0);
  assign access      = mem_op & ~me_misalign;

  assign shifted = dmem_resp_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = shifted;
    if (size_q == SIZEW'(1)) begin
      load_ext = {{(XLEN-8){~ext_un_q & shifted[7]}}, shifted[7:0]};
    end else if (size_q == SIZEW'(2)) begin
      load_ext = {{(XLEN-16){~ext_un_q & shifted[15]}}, shifted[15:0]};
    end else if (size_q == SIZEW'(4)) begin
      load_ext = {{(XLEN-32){~ext_un_q & shifted[31]}}, shifted[31:0]};
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wen_d       = wen_q;
    size_d      = size_q;
    off_d       = off_q;
    ext_un_d    = ext_un_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          addr_d   = {me_alu_result[XLEN-1:OFFW], {OFFW{1'b0}}};
          wdata_d  = me_new_rs2_data << {addr_off, 3'b000};
          wstrb_d  = me_mem_byte_enable;
          wen_d    = me_mem_wena;
          size_d   = size;
          off_d    = addr_off;
          ext_un_d = me_mem_ext_un;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (dmem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (dmem_resp_valid) begin
          if (!wen_q) load_data_d = load_ext;
          state_d = DONE;
        end
      end
      // EX/ME still holds this instruction during DONE; never re-issue it.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wen_q       <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      ext_un_q    <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wen_q       <= wen_d;
      size_q      <= size_d;
      off_q       <= off_d;
      ext_un_q    <= ext_un_d;
      load_data_q <= load_data_d;
    end
  end

  assign dmem_req_valid = (state_q == REQ);
  assign dmem_req_wen   = wen_q;
  assign dmem_req_addr  = addr_q;
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_wstrb = wstrb_q;
  assign me_load_data   = load_data_q;
  assign stall_req      = ((state_q == IDLE) & access) | (state_q == REQ) | (state_q == WAIT);

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access
// Expected load results are queued at stimulus time and popped when the DUT completes.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        me_mem_rena, me_mem_wena, me_mem_ext_un, me_exception_flag;
  logic [7:0]  me_mem_byte_enable;
  logic [63:0] me_alu_result, me_new_rs2_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_wen;
  logic [63:0] dmem_req_addr, dmem_req_wdata;
  logic [7:0]  dmem_req_wstrb;
  logic        dmem_resp_valid;
  logic [63:0] dmem_resp_rdata;
  logic [63:0] me_load_data;
  logic        me_misalign, stall_req;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .me_mem_rena(me_mem_rena), .me_mem_wena(me_mem_wena), .me_mem_ext_un(me_mem_ext_un),
    .me_mem_byte_enable(me_mem_byte_enable), .me_alu_result(me_alu_result),
    .me_new_rs2_data(me_new_rs2_data), .me_exception_flag(me_exception_flag),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_wen(dmem_req_wen),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .me_load_data(me_load_data), .me_misalign(me_misalign), .stall_req(stall_req)
  );

  function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                             input int size, input logic ext_un);
    logic [63:0] r, mask;
    r = rdata >> (8 * off);
    if (size < 8) begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      r = r & mask;
      if (!ext_un && r[8 * size - 1]) r = r | ~mask;
    end
    return r;
  endfunction

  task automatic drive_mem(input logic rena, input logic wena, input logic ext_un,
                           input logic [7:0] be, input logic [63:0] addr, input logic [63:0] rs2);
    @(posedge clk); #1;
    me_mem_rena = rena; me_mem_wena = wena; me_mem_ext_un = ext_un;
    me_mem_byte_enable = be; me_alu_result = addr; me_new_rs2_data = rs2;
    me_exception_flag = 1'b0;
  endtask

  task automatic clear_mem();
    me_mem_rena = 1'b0; me_mem_wena = 1'b0; me_mem_ext_un = 1'b0;
    me_mem_byte_enable = '0; me_alu_result = '0; me_new_rs2_data = '0;
    me_exception_flag = 1'b0;
  endtask

  // Bus responder: ready after ready_delay valid cycles, response one cycle after acceptance.
  // Returns at the negedge of the first non-stall cycle (DONE).
  task automatic run_txn(input logic [63:0] rdata, input int ready_delay,
                         output int stall_cnt, output bit to, output int unstable,
                         output logic [63:0] f_addr, output logic [63:0] f_wdata,
                         output logic [7:0] f_wstrb, output logic f_wen);
    int vcnt = 0;
    bit seen = 0;
    bit resp_pending = 0;
    stall_cnt = 0; to = 1'b1; unstable = 0;
    f_addr = '0; f_wdata = '0; f_wstrb = '0; f_wen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      dmem_resp_valid = 1'b0;
      if (!stall_req) begin
        to = 1'b0;
        break;
      end
      stall_cnt++;
      if (resp_pending) begin
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = rdata;
        resp_pending = 0;
      end
      if (dmem_req_valid) begin
        if (!seen) begin
          f_addr = dmem_req_addr; f_wdata = dmem_req_wdata;
          f_wstrb = dmem_req_wstrb; f_wen = dmem_req_wen;
          seen = 1;
        end else if (f_addr !== dmem_req_addr || f_wdata !== dmem_req_wdata ||
                     f_wstrb !== dmem_req_wstrb || f_wen !== dmem_req_wen) begin
          unstable++;
        end
        dmem_req_ready = (vcnt >= ready_delay);
        resp_pending = dmem_req_ready;
        vcnt++;
      end else begin
        dmem_req_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_mem();
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dmem_req_valid, dmem_req_wen, dmem_req_wstrb, stall_req, me_misalign} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_ctrl: got valid=%b wen=%b wstrb=%h stall=%b mis=%b, want all 0",
               dmem_req_valid, dmem_req_wen, dmem_req_wstrb, stall_req, me_misalign);
    end
    n_cmp++;
    if (dmem_req_addr !== 64'h0 || dmem_req_wdata !== 64'h0 || me_load_data !== 64'h0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h wdata=%h load=%h, want 0",
               dmem_req_addr, dmem_req_wdata, me_load_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_lb();
    int sc, un; bit to; logic [63:0] a, w, exp; logic [7:0] s; logic wn;
    drive_mem(1'b1, 1'b0, 1'b0, 8'h08, 64'h0000_0000_8000_0003, 64'h0);
    sb_q.push_back(64'hFFFF_FFFF_FFFF_FF80);
    run_txn(64'h0000_0000_8000_0000, 0, sc, to, un, a, w, s, wn);
    clear_mem();
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || sc != 3) begin
      n_err++; $display("FAIL lb_stall: got %0d cycles (timeout=%b), want 3", sc, to);
    end
    n_cmp++;
    if (a !== 64'h8000_0000 || s !== 8'h08 || wn !== 1'b0) begin
      n_err++; $display("FAIL lb_req: got addr=%h wstrb=%h wen=%b, want 80000000/08/0", a, s, wn);
    end
    n_cmp++;
    if (me_load_data !== exp) begin
      n_err++; $display("FAIL lb_data: got %h, want %h", me_load_data, exp);
    end
  endtask

  task automatic test_lwu();
    int sc, un; bit to; logic [63:0] a, w, exp; logic [7:0] s; logic wn;
    drive_mem(1'b1, 1'b0, 1'b1, 8'hF0, 64'h0000_0000_8000_0004, 64'h0);
    sb_q.push_back(64'h0000_0000_8765_4321);
    run_txn(64'h8765_4321_0000_0000, 0, sc, to, un, a, w, s, wn);
    clear_mem();
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || me_load_data !== exp) begin
      n_err++; $display("FAIL lwu_data: got %h (timeout=%b), want %h", me_load_data, to, exp);
    end
  endtask

  task automatic test_sh();
    int sc, un; bit to; logic [63:0] a, w, exp; logic [7:0] s; logic wn;
    sb_q.push_back(me_load_data);
    drive_mem(1'b0, 1'b1, 1'b0, 8'hC0, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_ABCD);
    run_txn(64'hDEAD_BEEF_CAFE_F00D, 0, sc, to, un, a, w, s, wn);
    clear_mem();
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || sc != 3) begin
      n_err++; $display("FAIL sh_stall: got %0d cycles (timeout=%b), want 3", sc, to);
    end
    n_cmp++;
    if (a !== 64'h8000_0000 || w !== 64'hABCD_0000_0000_0000 || s !== 8'hC0 || wn !== 1'b1) begin
      n_err++;
      $display("FAIL sh_req: got addr=%h wdata=%h wstrb=%h wen=%b, want 80000000/abcd000000000000/c0/1",
               a, w, s, wn);
    end
    n_cmp++;
    if (me_load_data !== exp) begin
      n_err++; $display("FAIL sh_load_kept: got %h, want %h", me_load_data, exp);
    end
  endtask

  task automatic test_ready_stall();
    int sc, un; bit to; logic [63:0] a, w, exp, rd; logic [7:0] s; logic wn;
    rd = {$urandom, $urandom};
    drive_mem(1'b1, 1'b1, 1'b0, 8'hFF, 64'h0000_0000_8000_0010, 64'h1122_3344_5566_7788);
    sb_q.push_back(me_load_data);
    run_txn(rd, 5, sc, to, un, a, w, s, wn);
    clear_mem();
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || sc != 8) begin
      n_err++; $display("FAIL ready_stall_cycles: got %0d (timeout=%b), want 8", sc, to);
    end
    n_cmp++;
    if (un != 0) begin
      n_err++; $display("FAIL ready_stall_stable: got %0d changed cycles, want 0", un);
    end
    n_cmp++;
    if (wn !== 1'b1 || w !== 64'h1122_3344_5566_7788 || me_load_data !== exp) begin
      n_err++; $display("FAIL rw_as_store: got wen=%b wdata=%h load=%h, want 1/1122334455667788/%h",
                        wn, w, me_load_data, exp);
    end
  endtask

  task automatic test_back_to_back();
    int sc, un, size, off; bit to; logic ext;
    logic [63:0] a, w, exp, rd; logic [7:0] s, be; logic wn;
    for (int k = 0; k < 6; k++) begin
      size = 1 << $urandom_range(3);
      off  = size * $urandom_range(8 / size - 1);
      ext  = 1'($urandom_range(1));
      be   = 8'(((1 << size) - 1) << off);
      rd   = {$urandom, $urandom};
      drive_mem(1'b1, 1'b0, ext, be, 64'h0000_0001_0000_0000 | 64'(off), 64'h0);
      sb_q.push_back(model_load(rd, off, size, ext));
      run_txn(rd, k % 3, sc, to, un, a, w, s, wn);
      clear_mem();
      exp = sb_q.pop_front();
      n_cmp++;
      if (to || sc != 3 + (k % 3) || me_load_data !== exp) begin
        n_err++;
        $display("FAIL b2b_%0d: got load=%h stall=%0d, want load=%h stall=%0d (size=%0d off=%0d ext_un=%b)",
                 k, me_load_data, sc, exp, 3 + (k % 3), size, off, ext);
      end
    end
  endtask

  task automatic test_misalign();
    bit saw_valid = 0, saw_stall = 0;
    logic [63:0] kept;
    kept = me_load_data;
    drive_mem(1'b1, 1'b0, 1'b0, 8'h3C, 64'h0000_0000_8000_0002, 64'h0);
    @(negedge clk);
    n_cmp++;
    if (me_misalign !== 1'b1) begin
      n_err++; $display("FAIL misalign_flag: got %b, want 1", me_misalign);
    end
    for (int c = 0; c < 4; c++) begin
      if (dmem_req_valid) saw_valid = 1;
      if (stall_req) saw_stall = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_valid || saw_stall) begin
      n_err++; $display("FAIL misalign_noreq: got valid_seen=%b stall_seen=%b, want 0/0", saw_valid, saw_stall);
    end
    me_exception_flag = 1'b1;
    saw_valid = 0; saw_stall = 0;
    #1;
    n_cmp++;
    if (me_misalign !== 1'b0) begin
      n_err++; $display("FAIL exc_misalign: got %b, want 0", me_misalign);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dmem_req_valid) saw_valid = 1;
      if (stall_req) saw_stall = 1;
    end
    n_cmp++;
    if (saw_valid || saw_stall || me_load_data !== kept) begin
      n_err++; $display("FAIL exc_noreq: got valid_seen=%b stall_seen=%b load=%h, want 0/0/%h",
                        saw_valid, saw_stall, me_load_data, kept);
    end
    clear_mem();
  endtask

  task automatic test_rst_wait();
    drive_mem(1'b1, 1'b0, 1'b0, 8'hFF, 64'h0000_0000_8000_0020, 64'h0);
    @(negedge clk);
    n_cmp++;
    if (stall_req !== 1'b1) begin
      n_err++; $display("FAIL rst_c0_stall: got %b, want 1", stall_req);
    end
    @(negedge clk);
    n_cmp++;
    if (dmem_req_valid !== 1'b1) begin
      n_err++; $display("FAIL rst_req_valid: got %b, want 1", dmem_req_valid);
    end
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    n_cmp++;
    if (dmem_req_valid !== 1'b0 || stall_req !== 1'b1) begin
      n_err++; $display("FAIL rst_wait_state: got valid=%b stall=%b, want 0/1", dmem_req_valid, stall_req);
    end
    rst = 1'b1;
    clear_mem();
    @(negedge clk);
    rst = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (me_load_data !== 64'h0 || stall_req !== 1'b0 || dmem_req_valid !== 1'b0 || dmem_req_addr !== 64'h0) begin
      n_err++; $display("FAIL rst_wait_idle: got load=%h stall=%b valid=%b addr=%h, want 0/0/0/0",
                        me_load_data, stall_req, dmem_req_valid, dmem_req_addr);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lwu();
    test_sh();
    test_ready_stall();
    test_back_to_back();
    test_misalign();
    test_rst_wait();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_empty: got %0d entries left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access (ME) stage, directly downstream of the EX/ME pipeline register.
- Consumes the registered me_* memory-control signals and performs one data-memory transaction per instruction over a valid/ready request, valid response bus.
- Aligns and extends load data, and holds the pipeline via stall_req until the transaction completes.
- Feeds the ME/WB register.

Parameters:
- XLEN, 64, data/address width
- BUS_BYTES, 8, data bus width in bytes; bus addresses are BUS_BYTES-aligned

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- me_mem_rena  in  1  load request
- me_mem_wena  in  1  store request
- me_mem_ext_un  in  1  1 = zero-extend load, 0 = sign-extend load
- me_mem_byte_enable  in  8  lane mask, already shifted to byte position addr[2:0]
- me_alu_result  in  XLEN  effective byte address
- me_new_rs2_data  in  XLEN  store data, unshifted, LSB-aligned
- me_exception_flag  in  1  instruction already faulted; suppress access
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  bus accepts request
- dmem_req_wen  out  1  1 = write
- dmem_req_addr  out  XLEN  {addr[63:3],3'b0}
- dmem_req_wdata  out  XLEN  rs2 << 8*addr[2:0]
- dmem_req_wstrb  out  8  = byte_enable
- dmem_resp_valid  in  1  response/ack, one cycle
- dmem_resp_rdata  in  XLEN  read data
- me_load_data  out  XLEN  aligned, extended load result
- me_misalign  out  1  access not naturally aligned; no bus transaction
- stall_req  out  1  hold EX/ME and upstream stages

Behaviour:
- Definitions:
  - access = (rena|wena) & ~exception_flag & ~misalign.
  - size = popcount(byte_enable), legal values 1, 2, 4, 8.
  - misalign = (rena|wena) & ~exception_flag & (addr[2:0] mod size != 0). Combinational; no transaction is issued.
- Reset values: state IDLE, dmem_req_valid 0, dmem_req_wen 0, dmem_req_addr 0, dmem_req_wdata 0, dmem_req_wstrb 0, me_load_data 0. me_misalign and stall_req are combinational and 0 when inputs are idle.
- FSM:
  - IDLE: if access, latch addr/wdata/wstrb/wen/size/offset/ext_un into request registers and go to REQ.
  - REQ: dmem_req_valid=1. On dmem_req_ready go to WAIT; otherwise stay. Request fields stay stable while valid and not ready.
  - WAIT: valid=0. On dmem_resp_valid capture the load result into me_load_data (loads only; stores leave it unchanged) and go to DONE.
  - DONE: one cycle, then IDLE unconditionally. No re-issue even though EX/ME still holds the same instruction.
- stall_req = (IDLE & access) | REQ | WAIT. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Latency with ready=1 and the response on the next cycle: detect (c0), REQ (c1), WAIT (c2), DONE (c3). Minimum 4 cycles occupancy.
- Load extraction:
  - raw = rdata >> 8*offset, truncated to 8·size bits.
  - Sign- or zero-extend to XLEN per ext_un; size 8 passes through unchanged.
- Exception flag or misalign: no transaction, stall_req 0, me_load_data unchanged.
- dmem_resp_valid arriving in IDLE, REQ, or DONE is ignored.
- rst mid-transaction returns to IDLE and drops valid the next cycle. A late response is ignored per the rule above.
- A stores-only instruction with rena=wena=1 is treated as a store (wen=1).

Test Plan:
- LB, addr 0x8000_0003, be 0x08, ext_un 0, rdata 0x0000_0000_8000_0000 → me_load_data 0xFFFF_FFFF_FFFF_FF80; stall_req high for exactly 3 cycles with ready=1 and resp next cycle.
- LWU, addr 0x...04, be 0xF0, ext_un 1, rdata 0x8765_4321_0000_0000 → me_load_data 0x0000_0000_8765_4321.
- SH, addr 0x...06, be 0xC0, rs2 0xABCD → req_addr 0x...00, wdata 0xABCD_0000_0000_0000, wstrb 0xC0, wen 1; completes on ack.
- dmem_req_ready held low for 5 cycles → valid held and fields stable, stall_req held; completes 2 cycles after ready rises.
- LW at addr 0x...02 → me_misalign 1, no dmem_req_valid, stall_req 0. Same access with exception_flag 1 → misalign 0, no request.
- rst asserted in WAIT, then resp_valid → state IDLE, me_load_data 0, stall_req 0, response ignored.
